udp_chan_mux: RTL and testbench

//  N-channel front end for the UDP/IP stack user interface; sits between user logic and udp_top.
//  TX: round-robin arbitration of NCH packet streams onto the single tx_usr_* stream, packet-atomic.
//  RX: demultiplexes rx_usr_* packets to channel k when dst port == BASE_PORT+k; other ports dropped.

---
 rtl/udp_chan_mux_pkg.sv | 25 ++
 rtl/udp_chan_mux_rr_arbiter.sv | 54 +++++
 rtl/udp_chan_mux.sv | 204 ++++++++++++++++++++
 tb/tb_udp_chan_mux.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_chan_mux_pkg.sv
// Shared widths, FSM encodings and port helper for the UDP channel mux.
package udp_chan_pkg;
    localparam int DATA_W   = 32;
    localparam int TXUSER_W = 64;
    localparam int RXUSER_W = 32;
    localparam int BE_W     = 4;
    localparam int PORT_W   = 16;

    typedef enum logic {
        T_IDLE = 1'b0,
        T_BUSY = 1'b1
    } tx_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_PASS = 2'd1,
        R_DROP = 2'd2
    } rx_state_t;

    // 16-bit wrapping subtraction: ports below the base land far above any channel index.
    function automatic logic [PORT_W-1:0] port_offset(input logic [PORT_W-1:0] port,
                                                      input logic [PORT_W-1:0] base);
        return port - base;
    endfunction
endpackage

// File: rtl/udp_chan_mux_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at/after rr_ptr on load, advances past the winner on done.
module udp_rr_arbiter #(
    parameter int NCH = 4,
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH-1:0]   req,
    input  logic             load,
    input  logic             done,
    output logic [NCH-1:0]   grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic [IDX_W-1:0] rr_ptr
);
    localparam logic [IDX_W:0]   NCH_L  = (IDX_W+1)'(NCH);
    localparam logic [IDX_W-1:0] LAST_L = IDX_W'(NCH - 1);

    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W:0]   cand;
    logic             found;

    always_comb begin
        pick_idx = rr_ptr;
        found    = 1'b0;
        cand     = '0;
        for (int i = 0; i < NCH; i++) begin
            cand = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            if (cand >= NCH_L) begin
                cand = cand - NCH_L;
            end
            if (!found && req[cand[IDX_W-1:0]]) begin
                found    = 1'b1;
                pick_idx = cand[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant     <= '0;
            grant_idx <= '0;
            rr_ptr    <= '0;
        end else begin
            if (load) begin
                grant     <= NCH'(1) << pick_idx;
                grant_idx <= pick_idx;
            end
            if (done) begin
                grant  <= '0;
                rr_ptr <= (grant_idx == LAST_L) ? '0 : grant_idx + IDX_W'(1);
            end
        end
    end
endmodule

// File: rtl/udp_chan_mux.sv
// N-channel TX arbiter / RX port demux in front of udp_top.
// Optional per-channel packet statistics are built when UDP_CHAN_STATS_EN is defined.
module udp_chan_mux
    import udp_chan_pkg::*;
#(
    parameter int              NCH       = 4,
    parameter logic [15:0]     BASE_PORT = 16'd8000,
    parameter int              CNT_W     = 16,
    localparam int             IDX_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                      sclk,
    input  logic                      reset,
    input  logic [NCH-1:0]            ch_tx_vld_i,
    input  logic [NCH*DATA_W-1:0]     ch_tx_data_i,
    input  logic [NCH*TXUSER_W-1:0]   ch_tx_user_i,
    input  logic [NCH*BE_W-1:0]       ch_tx_be_i,
    input  logic [NCH-1:0]            ch_tx_tlast_i,
    output logic [NCH-1:0]            ch_tx_ready_o,
    output logic                      tx_usr_data_vld_o,
    output logic [DATA_W-1:0]         tx_usr_data_o,
    output logic [TXUSER_W-1:0]       tx_user_o,
    output logic [BE_W-1:0]           tx_usr_be_o,
    output logic                      tx_usr_tlast_o,
    input  logic                      tx_usr_ready_i,
    input  logic                      rx_usr_data_vld_i,
    input  logic [DATA_W-1:0]         rx_usr_data_i,
    input  logic [RXUSER_W-1:0]       rx_user_i,
    input  logic [BE_W-1:0]           rx_usr_be_i,
    input  logic                      rx_usr_tlast_i,
    output logic                      rx_usr_ready_o,
    output logic [NCH-1:0]            ch_rx_vld_o,
    output logic [NCH*DATA_W-1:0]     ch_rx_data_o,
    output logic [NCH*RXUSER_W-1:0]   ch_rx_user_o,
    output logic [NCH*BE_W-1:0]       ch_rx_be_o,
    output logic [NCH-1:0]            ch_rx_tlast_o,
    input  logic [NCH-1:0]            ch_rx_ready_i,
    output logic [CNT_W-1:0]          rx_drop_cnt_o,
    output logic [NCH*2*CNT_W-1:0]    ch_stats_o,
    output logic                      dbg_tx_state,
    output logic [1:0]                dbg_rx_state,
    output logic [IDX_W-1:0]          dbg_rr_ptr
);
    // Handshake on every stream: a beat moves when vld and ready are both high in the
    // same cycle; vld never depends on ready, ready may depend on vld.

    localparam logic [PORT_W-1:0] NCH_PORT = PORT_W'(NCH);

    tx_state_t        tx_state;
    rx_state_t        rx_state;
    logic [NCH-1:0]   gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic [IDX_W-1:0] rr_ptr;
    logic             arb_load;
    logic             tx_done;

    logic [PORT_W-1:0] port_off;
    logic              port_match;
    logic [IDX_W-1:0]  first_ch;
    logic [IDX_W-1:0]  rx_ch;
    logic [IDX_W-1:0]  route_ch;
    logic              route_en;
    logic              rx_accept;
    logic [CNT_W-1:0]  drop_cnt;

    assign arb_load = (tx_state == T_IDLE) && (|ch_tx_vld_i);
    assign tx_done  = tx_usr_data_vld_o && tx_usr_ready_i && tx_usr_tlast_o;

    udp_rr_arbiter #(.NCH(NCH)) u_arb (
        .clk       (sclk),
        .reset     (reset),
        .req       (ch_tx_vld_i),
        .load      (arb_load),
        .done      (tx_done),
        .grant     (gnt),
        .grant_idx (gnt_idx),
        .rr_ptr    (rr_ptr)
    );

    // TX: the granted channel is wired straight through until its tlast is accepted.
    always_comb begin
        tx_usr_data_o     = ch_tx_data_i[gnt_idx*DATA_W +: DATA_W];
        tx_user_o         = ch_tx_user_i[gnt_idx*TXUSER_W +: TXUSER_W];
        tx_usr_be_o       = ch_tx_be_i[gnt_idx*BE_W +: BE_W];
        tx_usr_tlast_o    = ch_tx_tlast_i[gnt_idx];
        tx_usr_data_vld_o = 1'b0;
        ch_tx_ready_o     = '0;
        if (tx_state == T_BUSY) begin
            tx_usr_data_vld_o = ch_tx_vld_i[gnt_idx];
            ch_tx_ready_o     = gnt & {NCH{tx_usr_ready_i}};
        end
    end

    always_ff @(posedge sclk) begin
        if (reset) begin
            tx_state <= T_IDLE;
        end else begin
            case (tx_state)
                T_IDLE:  if (arb_load) tx_state <= T_BUSY;
                T_BUSY:  if (tx_done)  tx_state <= T_IDLE;
                default: tx_state <= T_IDLE;
            endcase
        end
    end

    // RX: the first beat is routed in the same cycle its port is decoded.
    assign port_off   = port_offset(rx_user_i[PORT_W-1:0], BASE_PORT);
    assign port_match = port_off < NCH_PORT;
    assign first_ch   = port_off[IDX_W-1:0];

    always_comb begin
        route_en       = 1'b0;
        route_ch       = rx_ch;
        rx_usr_ready_o = 1'b0;
        case (rx_state)
            R_IDLE: begin
                if (rx_usr_data_vld_i) begin
                    if (port_match) begin
                        route_en = 1'b1;
                        route_ch = first_ch;
                    end else begin
                        rx_usr_ready_o = 1'b1;
                    end
                end
            end
            R_PASS:  route_en = 1'b1;
            R_DROP:  rx_usr_ready_o = 1'b1;
            default: route_en = 1'b0;
        endcase
        if (route_en) begin
            rx_usr_ready_o = ch_rx_ready_i[route_ch];
        end
        ch_rx_vld_o = route_en ? (NCH'(rx_usr_data_vld_i) << route_ch) : '0;
    end

    assign rx_accept     = rx_usr_data_vld_i && rx_usr_ready_o;
    assign ch_rx_data_o  = {NCH{rx_usr_data_i}};
    assign ch_rx_user_o  = {NCH{rx_user_i}};
    assign ch_rx_be_o    = {NCH{rx_usr_be_i}};
    assign ch_rx_tlast_o = {NCH{rx_usr_tlast_i}};

    always_ff @(posedge sclk) begin
        if (reset) begin
            rx_state <= R_IDLE;
            rx_ch    <= '0;
            drop_cnt <= '0;
        end else begin
            case (rx_state)
                R_IDLE: begin
                    if (rx_usr_data_vld_i && !port_match && drop_cnt != '1) begin
                        drop_cnt <= drop_cnt + CNT_W'(1);
                    end
                    if (rx_accept && !rx_usr_tlast_i) begin
                        rx_ch    <= first_ch;
                        rx_state <= route_en ? R_PASS : R_DROP;
                    end
                end
                R_PASS, R_DROP: begin
                    if (rx_accept && rx_usr_tlast_i) rx_state <= R_IDLE;
                end
                default: rx_state <= R_IDLE;
            endcase
        end
    end

    assign rx_drop_cnt_o = drop_cnt;
    assign dbg_tx_state  = tx_state;
    assign dbg_rx_state  = rx_state;
    assign dbg_rr_ptr    = rr_ptr;

`ifdef UDP_CHAN_STATS_EN
    logic [CNT_W-1:0] tx_pkts [NCH];
    logic [CNT_W-1:0] rx_pkts [NCH];
    logic             rx_done;

    assign rx_done = route_en && rx_accept && rx_usr_tlast_i;

    always_ff @(posedge sclk) begin
        if (reset) begin
            for (int k = 0; k < NCH; k++) begin
                tx_pkts[k] <= '0;
                rx_pkts[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (tx_done && gnt_idx == IDX_W'(k) && tx_pkts[k] != '1) begin
                    tx_pkts[k] <= tx_pkts[k] + CNT_W'(1);
                end
                if (rx_done && route_ch == IDX_W'(k) && rx_pkts[k] != '1) begin
                    rx_pkts[k] <= rx_pkts[k] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        ch_stats_o = '0;
        for (int k = 0; k < NCH; k++) begin
            ch_stats_o[k*2*CNT_W +: 2*CNT_W] = {rx_pkts[k], tx_pkts[k]};
        end
    end
`else
    assign ch_stats_o = '0;
`endif
endmodule

// File: tb/tb_udp_chan_mux.sv
// Directed bench for udp_chan_mux: per-channel sources, TX/RX expected queues, final report.
module tb_udp_chan_mux;
  logic         sclk = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   ch_tx_vld_i = '0;
  logic [127:0] ch_tx_data_i = '0;
  logic [255:0] ch_tx_user_i = '0;
  logic [15:0]  ch_tx_be_i = '0;
  logic [3:0]   ch_tx_tlast_i = '0;
  logic [3:0]   ch_tx_ready_o;
  logic         tx_usr_data_vld_o;
  logic [31:0]  tx_usr_data_o;
  logic [63:0]  tx_user_o;
  logic [3:0]   tx_usr_be_o;
  logic         tx_usr_tlast_o;
  logic         tx_usr_ready_i = 1'b0;
  logic         rx_usr_data_vld_i = 1'b0;
  logic [31:0]  rx_usr_data_i = '0;
  logic [31:0]  rx_user_i = '0;
  logic [3:0]   rx_usr_be_i = '0;
  logic         rx_usr_tlast_i = 1'b0;
  logic         rx_usr_ready_o;
  logic [3:0]   ch_rx_vld_o;
  logic [127:0] ch_rx_data_o;
  logic [127:0] ch_rx_user_o;
  logic [15:0]  ch_rx_be_o;
  logic [3:0]   ch_rx_tlast_o;
  logic [3:0]   ch_rx_ready_i = '0;
  logic [15:0]  rx_drop_cnt_o;
  logic [127:0] ch_stats_o;
  logic         dbg_tx_state;
  logic [1:0]   dbg_rx_state;
  logic [1:0]   dbg_rr_ptr;

  udp_chan_mux #(.NCH(4), .BASE_PORT(16'd8000), .CNT_W(16)) dut (
    .sclk(sclk), .reset(reset),
    .ch_tx_vld_i(ch_tx_vld_i), .ch_tx_data_i(ch_tx_data_i), .ch_tx_user_i(ch_tx_user_i),
    .ch_tx_be_i(ch_tx_be_i), .ch_tx_tlast_i(ch_tx_tlast_i), .ch_tx_ready_o(ch_tx_ready_o),
    .tx_usr_data_vld_o(tx_usr_data_vld_o), .tx_usr_data_o(tx_usr_data_o), .tx_user_o(tx_user_o),
    .tx_usr_be_o(tx_usr_be_o), .tx_usr_tlast_o(tx_usr_tlast_o), .tx_usr_ready_i(tx_usr_ready_i),
    .rx_usr_data_vld_i(rx_usr_data_vld_i), .rx_usr_data_i(rx_usr_data_i), .rx_user_i(rx_user_i),
    .rx_usr_be_i(rx_usr_be_i), .rx_usr_tlast_i(rx_usr_tlast_i), .rx_usr_ready_o(rx_usr_ready_o),
    .ch_rx_vld_o(ch_rx_vld_o), .ch_rx_data_o(ch_rx_data_o), .ch_rx_user_o(ch_rx_user_o),
    .ch_rx_be_o(ch_rx_be_o), .ch_rx_tlast_o(ch_rx_tlast_o), .ch_rx_ready_i(ch_rx_ready_i),
    .rx_drop_cnt_o(rx_drop_cnt_o), .ch_stats_o(ch_stats_o),
    .dbg_tx_state(dbg_tx_state), .dbg_rx_state(dbg_rx_state), .dbg_rr_ptr(dbg_rr_ptr)
  );

  // ---------------- clock ----------------
  always #5 sclk = ~sclk;

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [103:0] tx_exp_q[$];   // {ch, data, user, be, tlast}
  logic [71:0]  rx_exp_q[$];   // {ch, data, user, be, tlast}
  logic [100:0] tx_mem [4][64];
  int           tx_wr [4];
  int           tx_rd [4];
  logic [3:0]   tx_acc;
  logic [68:0]  rx_mem [64];
  int           rx_wr = 0;
  int           rx_rd = 0;
  logic         rx_acc;
  int           tx_ready_mode = 1;  // 0 low, 1 high, 2 random
  int           rx_ready_mode = 1;  // 0 low, 1 high, 2 toggle, 3 random
  int           exp_tx_pkts [4];
  int           exp_rx_pkts [4];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic load_tx(input int ch, input int nbeats);
    logic [31:0] d;
    logic [63:0] u;
    logic [3:0]  b;
    logic        t;
    for (int i = 0; i < nbeats; i++) begin
      d = $urandom;
      u = {$urandom, 16'(8000 + ch), 16'($urandom_range(1024, 65535))};
      t = (i == nbeats - 1);
      b = t ? 4'($urandom_range(1, 15)) : 4'hf;
      tx_mem[ch][tx_wr[ch] % 64] = {d, u, b, t};
      tx_wr[ch]++;
      tx_exp_q.push_back({3'(ch), d, u, b, t});
    end
    exp_tx_pkts[ch]++;
  endtask

  // exp_ch < 0 means the packet must be dropped
  task automatic load_rx(input logic [15:0] port, input int nbeats, input int exp_ch);
    logic [31:0] d;
    logic [31:0] u;
    logic [3:0]  b;
    logic        t;
    for (int i = 0; i < nbeats; i++) begin
      d = $urandom;
      u = {16'($urandom), port};
      t = (i == nbeats - 1);
      b = t ? 4'($urandom_range(1, 15)) : 4'hf;
      rx_mem[rx_wr % 64] = {d, u, b, t};
      rx_wr++;
      if (exp_ch >= 0) rx_exp_q.push_back({3'(exp_ch), d, u, b, t});
    end
    if (exp_ch >= 0) exp_rx_pkts[exp_ch]++;
  endtask

  initial begin : tx_src
    logic [100:0] e;
    forever begin
      @(negedge sclk);
      tx_acc = ch_tx_vld_i & ch_tx_ready_o;
      @(posedge sclk);
      #1;
      for (int c = 0; c < 4; c++) begin
        if (tx_acc[c] && tx_rd[c] < tx_wr[c]) tx_rd[c]++;
        if (tx_rd[c] < tx_wr[c]) begin
          e = tx_mem[c][tx_rd[c] % 64];
          ch_tx_vld_i[c] = 1'b1;
          ch_tx_data_i[c*32 +: 32] = e[100:69];
          ch_tx_user_i[c*64 +: 64] = e[68:5];
          ch_tx_be_i[c*4 +: 4] = e[4:1];
          ch_tx_tlast_i[c] = e[0];
        end else begin
          ch_tx_vld_i[c] = 1'b0;
        end
      end
    end
  end

  initial begin : rx_src
    logic [68:0] e;
    forever begin
      @(negedge sclk);
      rx_acc = rx_usr_data_vld_i & rx_usr_ready_o;
      @(posedge sclk);
      #1;
      if (rx_acc && rx_rd < rx_wr) rx_rd++;
      if (rx_rd < rx_wr) begin
        e = rx_mem[rx_rd % 64];
        rx_usr_data_vld_i = 1'b1;
        rx_usr_data_i = e[68:37];
        rx_user_i = e[36:5];
        rx_usr_be_i = e[4:1];
        rx_usr_tlast_i = e[0];
      end else begin
        rx_usr_data_vld_i = 1'b0;
      end
    end
  end

  initial begin : ready_drv
    forever begin
      @(posedge sclk);
      #1;
      case (tx_ready_mode)
        0:       tx_usr_ready_i = 1'b0;
        1:       tx_usr_ready_i = 1'b1;
        default: tx_usr_ready_i = ($urandom_range(0, 3) != 0);
      endcase
      case (rx_ready_mode)
        0:       ch_rx_ready_i = '0;
        1:       ch_rx_ready_i = '1;
        2:       ch_rx_ready_i = ~ch_rx_ready_i;
        default: ch_rx_ready_i = 4'($urandom_range(0, 15));
      endcase
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [103:0] te;
    logic [71:0]  re;
    forever begin
      @(negedge sclk);
      if (!reset) begin
        if (tx_usr_data_vld_o && tx_usr_ready_i) begin
          if (tx_exp_q.size() == 0) begin
            check("tx_unexpected_beat", 1, 0);
          end else begin
            te = tx_exp_q.pop_front();
            check("tx_beat", {tx_usr_data_o, tx_user_o, tx_usr_be_o, tx_usr_tlast_o}, te[100:0]);
            check("tx_ready_onehot", ch_tx_ready_o, 4'b0001 << te[103:101]);
          end
        end
        check("rx_vld_onehot0", $onehot0(ch_rx_vld_o), 1);
        for (int k = 0; k < 4; k++) begin
          if (ch_rx_vld_o[k]) begin
            check("rx_stall_mirror", rx_usr_ready_o, ch_rx_ready_i[k]);
            if (ch_rx_ready_i[k]) begin
              if (rx_exp_q.size() == 0) begin
                check("rx_unexpected_beat", 1, 0);
              end else begin
                re = rx_exp_q.pop_front();
                check("rx_channel", k, re[71:69]);
                check("rx_beat", {ch_rx_data_o[k*32 +: 32], ch_rx_user_o[k*32 +: 32],
                                  ch_rx_be_o[k*4 +: 4], ch_rx_tlast_o[k]}, re[68:0]);
              end
            end
          end
        end
      end
    end
  end

  // ---------------- helpers for the main sequence ----------------
  function automatic logic all_drained();
    logic ok;
    ok = (tx_exp_q.size() == 0) && (rx_exp_q.size() == 0) && (rx_rd == rx_wr);
    for (int c = 0; c < 4; c++) if (tx_rd[c] != tx_wr[c]) ok = 1'b0;
    return ok;
  endfunction

  task automatic wait_drain(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 600 && !ok; i++) begin
      @(negedge sclk);
      ok = all_drained();
    end
    check(tag, ok, 1);
    @(negedge sclk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_tx_vld"}, tx_usr_data_vld_o, 0);
    check({tag, "_ch_tx_ready"}, ch_tx_ready_o, 0);
    check({tag, "_rx_ready"}, rx_usr_ready_o, 0);
    check({tag, "_ch_rx_vld"}, ch_rx_vld_o, 0);
    check({tag, "_rr_ptr"}, dbg_rr_ptr, 0);
    check({tag, "_tx_state"}, dbg_tx_state, 0);
    check({tag, "_rx_state"}, dbg_rx_state, 0);
    check({tag, "_drop_cnt"}, rx_drop_cnt_o, 0);
    check({tag, "_stats"}, ch_stats_o, 0);
  endtask

  task automatic clear_model();
    for (int c = 0; c < 4; c++) begin
      exp_tx_pkts[c] = 0;
      exp_rx_pkts[c] = 0;
      tx_rd[c] = tx_wr[c];
      ch_tx_vld_i[c] = 1'b0;
    end
    tx_exp_q.delete();
  endtask

  task automatic check_stats(input string tag);
    logic [127:0] exp;
    exp = '0;
`ifdef UDP_CHAN_STATS_EN
    for (int c = 0; c < 4; c++) begin
      exp[c*32 +: 32] = {16'(exp_rx_pkts[c]), 16'(exp_tx_pkts[c])};
    end
`endif
    check(tag, ch_stats_o, exp);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    reset = 1'b1;
    repeat (3) @(posedge sclk);
    @(negedge sclk);
    check_idle_outputs("reset");
    reset = 1'b0;

    // tie with rr_ptr=0: ch0 then ch2
    tx_ready_mode = 1;
    load_tx(0, 2);
    load_tx(2, 3);
    wait_drain("tie0_drain");
    check("tie0_rr_ptr", dbg_rr_ptr, 3);

    // ch1 alone, 3 beats, random back-pressure; one-cycle grant latency
    tx_ready_mode = 2;
    load_tx(1, 3);
    @(negedge sclk);
    check("grant_latency_vld", tx_usr_data_vld_o, 0);
    check("grant_latency_state", dbg_tx_state, 0);
    @(negedge sclk);
    check("granted_vld", tx_usr_data_vld_o, 1);
    check("granted_state", dbg_tx_state, 1);
    wait_drain("ch1_drain");
    check("ch1_rr_ptr", dbg_rr_ptr, 2);

    // move rr_ptr to 1, then tie ch0/ch2 -> ch2 first
    load_tx(0, 1);
    wait_drain("ch0_single_drain");
    check("rr_ptr_after_ch0", dbg_rr_ptr, 1);
    load_tx(2, 2);
    load_tx(0, 2);
    wait_drain("tie1_drain");
    check("tie1_rr_ptr", dbg_rr_ptr, 1);

    // RX to port 8002 with ch_rx_ready_i toggling
    rx_ready_mode = 2;
    load_rx(16'd8002, 4, 2);
    wait_drain("rx_ch2_drain");

    // back-to-back single-beat and multi-beat RX packets
    rx_ready_mode = 3;
    load_rx(16'd8000, 1, 0);
    load_rx(16'd8003, 2, 3);
    load_rx(16'd8001, 1, 1);
    wait_drain("rx_b2b_drain");

    // unmatched ports are swallowed
    load_rx(16'd7999, 2, -1);
    load_rx(16'd8004, 3, -1);
    wait_drain("rx_drop_drain");
    check("drop_cnt_2", rx_drop_cnt_o, 2);
    load_rx(16'd1234, 1, -1);
    load_rx(16'd8001, 1, 1);
    wait_drain("rx_drop_single_drain");
    check("drop_cnt_3", rx_drop_cnt_o, 3);
    check_stats("stats_mid");

    // leave rr_ptr at 3, then reset during beat 2 of a ch1 packet
    tx_ready_mode = 1;
    load_tx(2, 1);
    wait_drain("pre_reset_drain");
    check("pre_reset_rr_ptr", dbg_rr_ptr, 3);
    load_tx(1, 3);
    repeat (3) @(posedge sclk);
    #2;
    check("beat2_busy", dbg_tx_state, 1);
    reset = 1'b1;
    @(posedge sclk);
    @(negedge sclk);
    check_idle_outputs("mid_reset");
    reset = 1'b0;
    clear_model();

    // fresh arbitration from rr_ptr=0: ch1 wins over ch3
    load_tx(1, 2);
    load_tx(3, 2);
    wait_drain("post_reset_tie_drain");
    check("post_reset_rr_ptr", dbg_rr_ptr, 0);

    // five packets on ch3 from a clean reset, plus one RX packet
    @(negedge sclk);
    reset = 1'b1;
    @(posedge sclk);
    @(negedge sclk);
    reset = 1'b0;
    clear_model();
    check("reset2_drop_cnt", rx_drop_cnt_o, 0);
    tx_ready_mode = 2;
    for (int p = 0; p < 5; p++) load_tx(3, 2);
    load_rx(16'd8002, 2, 2);
    wait_drain("stats_drain");
    check("stats_ch3_tx_pkts", exp_tx_pkts[3], 5);
    check_stats("stats_final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
